// File: rtl/note_envelope_shaper.sv
`default_nettype none
// ============================================================================
// Module   : note_envelope_shaper
// Purpose  : ADSR amplitude envelope for the tinytone sound path. A level
//            machine (IDLE/ATTACK/DECAY/SUSTAIN/RELEASE) runs once per note.
//            The level gates the raw square wave through a fast amplitude
//            PWM, and the result is registered onto sound_o.
// Ports    : clk_i, rst_i          clock, synchronous active-high reset
//            note_strb_i, rest_i  note boundary pulse, rest flag for the note
//            tone_i               raw 1-bit square wave
//            attack/decay/release_step_i  clocks per level step (0 acts as 1)
//            sustain_level_i      level held in SUSTAIN
//            sound_o              gated tone, 1 clock after tone_i
//            level_o, state_o     envelope level and state registers
// Revision : 1.0 - initial release
// ============================================================================
module note_envelope_shaper #(
    parameter int LEVEL_BW = 4,
    parameter int STEP_BW  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                note_strb_i,
    input  logic                rest_i,
    input  logic                tone_i,
    input  logic [STEP_BW-1:0]  attack_step_i,
    input  logic [STEP_BW-1:0]  decay_step_i,
    input  logic [STEP_BW-1:0]  release_step_i,
    input  logic [LEVEL_BW-1:0] sustain_level_i,
    output logic                sound_o,
    output logic [LEVEL_BW-1:0] level_o,
    output logic [2:0]          state_o
);

    localparam logic [LEVEL_BW-1:0] c_LEVEL_MAX = {LEVEL_BW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    logic [LEVEL_BW-1:0] r_level;
    logic [STEP_BW-1:0]  r_step_cnt;
    logic [LEVEL_BW-1:0] r_amp_cnt;
    logic                r_sound;

    state_t              w_next_state;
    logic [LEVEL_BW-1:0] w_next_level;
    logic [STEP_BW-1:0]  w_next_cnt;
    logic [STEP_BW-1:0]  w_step_sel;
    logic [STEP_BW-1:0]  w_step_eff;
    logic                w_tick;
    logic [LEVEL_BW-1:0] w_lvl_inc;
    logic [LEVEL_BW-1:0] w_lvl_dec;

    // Step period of the current state; a programmed 0 behaves like 1.
    always_comb begin
        w_step_sel = '0;
        case (r_state)
            S_ATTACK:  w_step_sel = attack_step_i;
            S_DECAY:   w_step_sel = decay_step_i;
            S_RELEASE: w_step_sel = release_step_i;
            default:   w_step_sel = '0;
        endcase
        w_step_eff = (w_step_sel == '0) ? STEP_BW'(1) : w_step_sel;
        w_tick     = (r_step_cnt == (w_step_eff - STEP_BW'(1)));
        w_lvl_inc  = r_level + LEVEL_BW'(1);
        w_lvl_dec  = r_level - LEVEL_BW'(1);
    end

    always_comb begin
        w_next_state = r_state;
        w_next_level = r_level;
        w_next_cnt   = '0;

        if (note_strb_i) begin
            // Retrigger keeps the current level so a new note never clicks.
            if (!rest_i)
                w_next_state = S_ATTACK;
            else if (r_level != '0)
                w_next_state = S_RELEASE;
            else
                w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_level = '0;
                end
                S_ATTACK: begin
                    w_next_cnt = w_tick ? '0 : r_step_cnt + STEP_BW'(1);
                    if (r_level == c_LEVEL_MAX) begin
                        w_next_state = S_DECAY;
                    end else if (w_tick) begin
                        w_next_level = w_lvl_inc;
                        if (w_lvl_inc == c_LEVEL_MAX)
                            w_next_state = S_DECAY;
                    end
                end
                S_DECAY: begin
                    w_next_cnt = w_tick ? '0 : r_step_cnt + STEP_BW'(1);
                    if (r_level <= sustain_level_i) begin
                        w_next_state = S_SUSTAIN;
                    end else if (w_tick) begin
                        w_next_level = w_lvl_dec;
                        if (w_lvl_dec <= sustain_level_i)
                            w_next_state = S_SUSTAIN;
                    end
                end
                S_SUSTAIN: begin
                    w_next_level = r_level;
                end
                S_RELEASE: begin
                    w_next_cnt = w_tick ? '0 : r_step_cnt + STEP_BW'(1);
                    if (r_level == '0) begin
                        w_next_state = S_IDLE;
                    end else if (w_tick) begin
                        w_next_level = w_lvl_dec;
                        if (w_lvl_dec == '0)
                            w_next_state = S_IDLE;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_level = '0;
                end
            endcase
        end

        // Every note boundary and every state change restarts the step timer.
        if (note_strb_i || (w_next_state != r_state))
            w_next_cnt = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_level    <= '0;
            r_step_cnt <= '0;
            r_amp_cnt  <= '0;
            r_sound    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_level    <= w_next_level;
            r_step_cnt <= w_next_cnt;
            r_amp_cnt  <= r_amp_cnt + LEVEL_BW'(1);
            r_sound    <= tone_i & (r_amp_cnt < r_level);
        end
    end

    assign sound_o = r_sound;
    assign level_o = r_level;
    assign state_o = r_state;

endmodule
`default_nettype wire
